// File: rtl/rv_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_memory_arbiter
// Brief    : Round-robin arbiter that shares one single-port block RAM
//            (1-cycle registered read) between NUM_PORTS requesters, each with
//            a valid/ready request channel and a valid/ready read response.
// Revision : 1.0 - initial release
// ============================================================================
module rv_memory_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PORT_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_PORTS-1:0]             resp_valid,
    input  logic [NUM_PORTS-1:0]             resp_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_data,
    output logic                             mem_enable,
    output logic                             mem_write_enable,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    input  logic [DATA_WIDTH-1:0]            mem_data_out
);

    // After reset the search starts just past the last port, i.e. at port 0.
    localparam logic [PORT_WIDTH-1:0] C_LAST_PORT = PORT_WIDTH'(NUM_PORTS - 1);

    logic [PORT_WIDTH-1:0]           r_last_grant;
    logic [NUM_PORTS-1:0]            r_pend;
    logic [NUM_PORTS-1:0]            r_resp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_resp_data;

    logic [NUM_PORTS-1:0]            w_elig;
    logic [NUM_PORTS-1:0]            w_grant;
    logic [PORT_WIDTH-1:0]           w_grant_idx;
    logic                            w_grant_any;
    int                              w_cand;

    // Eligibility: writes always eligible; a read needs a free response slot
    // (no read in flight and the held response either absent or draining now).
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = req_valid[i] &&
                        (req_write[i] || (!r_pend[i] && (!r_resp_valid[i] || resp_ready[i])));
        end
    end

    // Round-robin search from last_grant+1; no grant while reset is asserted.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        w_cand      = 0;
        if (rst) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                w_cand = (int'(r_last_grant) + k) % NUM_PORTS;
                if (!w_grant_any && w_elig[w_cand]) begin
                    w_grant_any     = 1'b1;
                    w_grant_idx     = PORT_WIDTH'(w_cand);
                    w_grant[w_cand] = 1'b1;
                end
            end
        end
    end

    // One-hot mux of the winning port onto the RAM interface (zero when idle).
    always_comb begin
        mem_enable       = w_grant_any;
        mem_write_enable = |(w_grant & req_write);
        mem_addr         = '0;
        mem_data_in      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                mem_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Grant pointer and the one-cycle "read data arriving next cycle" marker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= C_LAST_PORT;
            r_pend       <= '0;
        end else begin
            if (w_grant_any) begin
                r_last_grant <= w_grant_idx;
            end
            r_pend <= w_grant & ~req_write;
        end
    end

    // Response holding registers: capture RAM data when pending, else drain on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_pend[i]) begin
                    r_resp_valid[i]                           <= 1'b1;
                    r_resp_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_data_out;
                end else if (r_resp_valid[i] && resp_ready[i]) begin
                    r_resp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_rv_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_memory_arbiter
// Brief    : Self-checking bench for rv_memory_arbiter with a behavioural RAM,
//            a transaction-level reference model, directed and random steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_memory_arbiter;

    localparam int NP = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NP-1:0]      req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [NP*AW-1:0]   req_addr;
    logic [NP*DW-1:0]   req_data, resp_data;
    logic               mem_enable, mem_write_enable;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_data_in, mem_data_out;

    int total = 0;
    int bad   = 0;
    int grant_cnt  = 0;
    int grant0_cnt = 0;
    int grant1_cnt = 0;

    // Reference model state: expected RAM contents and per-port response state.
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram   [0:(1<<AW)-1];
    int            m_last;
    bit [NP-1:0]   m_inflight;
    bit [NP-1:0]   m_rv;
    logic [DW-1:0] m_fly_data [NP];
    logic [DW-1:0] m_rd       [NP];

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, old data on read-during-write.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_write_enable) ram[mem_addr] <= mem_data_in;
            mem_data_out <= ram[mem_addr];
        end
    end

    rv_memory_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last     = NP - 1;
        m_inflight = '0;
        m_rv       = '0;
        for (int p = 0; p < NP; p++) begin
            m_fly_data[p] = '0;
            m_rd[p]       = '0;
        end
    endtask

    task automatic drive(input int p, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p]       = v;
        req_write[p]       = w;
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
    endtask

    // Called just after a falling edge with inputs applied: predict, compare,
    // advance the model across the coming rising edge, return at next falling edge.
    task automatic tick();
        int            win;
        logic [NP-1:0] exp_ready;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        logic          exp_we;
        #1;
        if (!rst) model_reset();
        win = -1;
        if (rst) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (win < 0 && req_valid[p] &&
                    (req_write[p] || (!m_inflight[p] && (!m_rv[p] || resp_ready[p]))))
                    win = p;
            end
        end
        exp_ready = '0;
        exp_addr  = '0;
        exp_din   = '0;
        exp_we    = 1'b0;
        if (win >= 0) begin
            exp_ready[win] = 1'b1;
            exp_addr = req_addr[win*AW +: AW];
            exp_din  = req_data[win*DW +: DW];
            exp_we   = req_write[win];
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("mem_enable", 64'(mem_enable), 64'(win >= 0));
        check("mem_we", 64'(mem_write_enable), 64'(exp_we));
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check("mem_data_in", 64'(mem_data_in), 64'(exp_din));
        check("resp_valid", 64'(resp_valid), 64'(m_rv));
        for (int p = 0; p < NP; p++)
            check($sformatf("resp_data%0d", p), 64'(resp_data[p*DW +: DW]), 64'(m_rd[p]));
        if (req_ready != '0) grant_cnt++;
        if (req_ready[0]) grant0_cnt++;
        if (req_ready[1]) grant1_cnt++;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                if (m_inflight[p]) begin
                    m_rv[p] = 1'b1;
                    m_rd[p] = m_fly_data[p];
                    m_inflight[p] = 1'b0;
                end else if (m_rv[p] && resp_ready[p]) begin
                    m_rv[p] = 1'b0;
                end
            end
            if (win >= 0) begin
                m_last = win;
                if (exp_we) m_mem[exp_addr] = exp_din;
                else begin
                    m_inflight[win] = 1'b1;
                    m_fly_data[win] = m_mem[exp_addr];
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int g0;
        bit seen1;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        model_reset();
        req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; resp_ready = '0;
        #2 rst = 1'b0;

        // Reset state: nothing granted, no responses.
        @(negedge clk);
        req_valid = 2'b11;
        tick();
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_data", 64'(resp_data), 64'd0);
        rst = 1'b1;
        idle();
        tick();

        // Port 0 writes DEADBEEF to addr 5, then reads it back with latency 2.
        drive(0, 1, 1, 10'd5, 32'hDEADBEEF);
        tick();
        idle();
        tick();
        drive(0, 1, 0, 10'd5, 32'h0);
        tick();
        idle();
        tick();
        check("rd5_valid", 64'(resp_valid[0]), 64'd1);
        check("rd5_data", 64'(resp_data[0 +: DW]), 64'hDEADBEEF);

        // Both ports read every cycle with resp_ready high: a grant every cycle.
        resp_ready = 2'b11;
        g0 = grant_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, AW'($urandom_range(0, 7)), 32'h0);
            drive(1, 1, 0, AW'($urandom_range(0, 7)), 32'h0);
            tick();
        end
        check("rr_grants", 64'(grant_cnt - g0), 64'd8);
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Port 0 response held for 10 cycles while port 1 keeps writing.
        resp_ready = 2'b10;
        g0 = grant0_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 10'd5, 32'h0);
            drive(1, 1, 1, AW'(32 + i), $urandom);
            tick();
        end
        check("hold_valid", 64'(resp_valid[0]), 64'd1);
        check("hold_data", 64'(resp_data[0 +: DW]), 64'hDEADBEEF);
        check("hold_one_grant", 64'(grant0_cnt - g0), 64'd1);
        resp_ready = 2'b11;
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Fairness: port 1 is served within 2 cycles despite port 0 streaming.
        seen1 = 1'b0;
        g0 = grant1_cnt;
        drive(1, 1, 1, 10'd40, 32'h5555AAAA);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, AW'(48 + i), $urandom);
            tick();
            if (grant1_cnt != g0) begin
                seen1 = 1'b1;
                drive(1, 0, 0, 10'd0, 32'h0);
            end
        end
        check("fair_port1", 64'(seen1), 64'd1);
        idle();
        tick();

        // Write by port 0 then read of the same address by port 1 next cycle.
        drive(0, 1, 1, 10'd3, 32'h11);
        tick();
        idle();
        drive(1, 1, 0, 10'd3, 32'h0);
        tick();
        idle();
        tick();
        check("raw_valid", 64'(resp_valid[1]), 64'd1);
        check("raw_data", 64'(resp_data[DW +: DW]), 64'h11);
        tick();

        // Reset between a read grant and its response: response is discarded.
        drive(1, 1, 0, 10'd3, 32'h0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        drive(0, 1, 0, 10'd5, 32'h0);
        drive(1, 1, 0, 10'd3, 32'h0);
        #1;
        check("rst_mid_grant0", 64'(req_ready), 64'd1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Randomised traffic with occasional resets, checked by the model.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++)
                drive(p, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                      AW'($urandom_range(0, 7)), $urandom);
            resp_ready = NP'($urandom);
            rst = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst = 1'b1;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
